// File: rtl/fir_poly_pkg.sv
// Shared types and constants for the polyphase FIR sequencer.
package fir_poly_pkg;
  localparam int OS_FACTOR = 4;
  localparam int NB_PHASE  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_STOP  = 2'd3
  } state_e;
endpackage

// File: rtl/sync_fifo.sv
// Small single-clock symbol FIFO; head is the oldest entry, occupancy drives full/empty.
module sync_fifo #(
  parameter int NB_DATA    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_pop,
  output logic               o_full,
  output logic               o_empty,
  output logic [NB_DATA-1:0] o_head
);
  localparam int NB_PTR = $clog2(FIFO_DEPTH);
  localparam logic [NB_PTR:0] DEPTH_C = FIFO_DEPTH[NB_PTR:0];

  logic [NB_DATA-1:0] r_mem [FIFO_DEPTH];
  logic [NB_PTR-1:0]  r_wr_ptr;
  logic [NB_PTR-1:0]  r_rd_ptr;
  logic [NB_PTR:0]    r_count;
  logic               w_push;
  logic               w_pop;

  // A push while full is dropped, so the caller may drive push straight from upstream valid.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == DEPTH_C);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + NB_PTR'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + NB_PTR'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (NB_PTR+1)'(1);
        2'b01:   r_count <= r_count - (NB_PTR+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end
endmodule

// File: rtl/fir_poly_sequencer.sv
// Paces a 4-phase polyphase FIR: prescaled ticks, one symbol pop every 4th tick,
// filter clear at run start, and a clean stop on a symbol boundary.
module fir_poly_sequencer
  import fir_poly_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int NB_PRESCALE = 8
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic                   i_run,
  input  logic [NB_PRESCALE-1:0] i_prescale,
  input  logic [NB_DATA-1:0]     i_data,
  input  logic                   i_data_valid,
  output logic                   o_data_ready,
  output logic [NB_DATA-1:0]     o_fir_data,
  output logic                   o_fir_enable,
  output logic                   o_fir_valid,
  output logic                   o_fir_reset,
  output logic [NB_PHASE-1:0]    o_phase,
  output logic                   o_out_valid,
  output logic                   o_underrun,
  output logic                   o_busy
);
  localparam logic [NB_PHASE-1:0] LAST_PHASE = NB_PHASE'(OS_FACTOR - 1);

  state_e                 r_state;
  logic [NB_PRESCALE-1:0] r_count;
  logic [NB_PRESCALE-1:0] r_prescale;
  logic [NB_PHASE-1:0]    r_phase;
  logic [NB_PHASE-1:0]    r_phase_out;
  logic [NB_DATA-1:0]     r_fir_data;
  logic                   r_fir_enable;
  logic                   r_fir_valid;
  logic                   r_fir_reset;
  logic                   r_underrun;
  logic                   w_full;
  logic                   w_empty;
  logic [NB_DATA-1:0]     w_head;
  logic                   w_tick;
  logic                   w_pop;

  sync_fifo #(
    .NB_DATA    (NB_DATA),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .i_reset (i_reset),
    .i_push  (i_data_valid),
    .i_data  (i_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign w_tick = (r_count == r_prescale);
  // Pops happen only on a phase-0 tick while still running; STOP only drains phases 1..3.
  assign w_pop  = (r_state == ST_RUN) && i_run && w_tick && (r_phase == '0) && !w_empty;

  assign o_data_ready = !w_full;
  assign o_fir_data   = r_fir_data;
  assign o_fir_enable = r_fir_enable;
  assign o_fir_valid  = r_fir_valid;
  assign o_fir_reset  = r_fir_reset;
  assign o_phase      = r_phase_out;
  assign o_out_valid  = r_fir_enable;
  assign o_underrun   = r_underrun;
  assign o_busy       = (r_state != ST_IDLE);

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_prescale   <= '0;
      r_phase      <= '0;
      r_phase_out  <= '0;
      r_fir_data   <= '0;
      r_fir_enable <= 1'b0;
      r_fir_valid  <= 1'b0;
      r_fir_reset  <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_fir_enable <= 1'b0;
      r_fir_valid  <= 1'b0;
      r_fir_reset  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_run) begin
            r_state     <= ST_FLUSH;
            r_fir_reset <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          r_count    <= '0;
          r_phase    <= '0;
          r_underrun <= 1'b0;
          r_prescale <= i_prescale;
          r_state    <= ST_RUN;
        end
        ST_RUN, ST_STOP: begin
          if (!i_run && (r_phase == '0)) begin
            r_state <= ST_IDLE;
          end else begin
            if (!i_run) begin
              r_state <= ST_STOP;
            end
            r_count <= w_tick ? '0 : r_count + NB_PRESCALE'(1);
            if (w_tick) begin
              if (r_phase != '0) begin
                r_fir_enable <= 1'b1;
                r_phase_out  <= r_phase;
                r_phase      <= r_phase + NB_PHASE'(1);
                // Finishing the last phase of a symbol is the only exit from STOP.
                if ((r_phase == LAST_PHASE) && (!i_run || (r_state == ST_STOP))) begin
                  r_state <= ST_IDLE;
                end
              end else if (w_pop) begin
                r_fir_enable <= 1'b1;
                r_fir_valid  <= 1'b1;
                r_fir_data   <= w_head;
                r_phase_out  <= '0;
                r_phase      <= NB_PHASE'(1);
              end else begin
                r_underrun <= 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/fir_poly_sequencer.md
Name: fir_poly_sequencer

Overview:
- Sequencer for the 4-phase polyphase RC FIR (x4 oversampling transmit shaper).
- Accepts symbols through a valid/ready handshake and buffers them in a small FIFO.
- Paces the filter with a programmable tick prescaler: one enable per tick, and a new sample (valid) every 4th tick.
- Clears the filter at run start and reports the current phase and output-sample validity to downstream logic.

Parameters:
- NB_DATA, 8, symbol width; must match the filter NB_INPUT.
- FIFO_DEPTH, 4, symbol buffer depth; power of two, ≥2.
- NB_PRESCALE, 8, width of the tick prescaler.
- OS_FACTOR, 4, phases per symbol; fixed at 4 to match the filter phase selector.

Ports:
- clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_run  in  1  level; 1 = run, 0 = stop at the next symbol boundary.
- i_prescale  in  NB_PRESCALE  tick period minus 1; sampled in FLUSH.
- i_data  in  NB_DATA  symbol from upstream.
- i_data_valid  in  1  upstream symbol valid.
- o_data_ready  out  1  FIFO not full.
- o_fir_data  out  NB_DATA  sample to the filter i_data.
- o_fir_enable  out  1  filter i_enable; 1-cycle pulse per tick.
- o_fir_valid  out  1  filter i_valid; asserted with enable at phase 0 only.
- o_fir_reset  out  1  filter reset; active-high, synchronous to the filter.
- o_phase  out  2  filter phase selector mirror for the current enable cycle.
- o_out_valid  out  1  filter o_data is a valid output sample this cycle.
- o_underrun  out  1  sticky; a phase-0 tick found the FIFO empty.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - State = IDLE; FIFO emptied; tick counter = 0; phase = 0.
  - All outputs = 0, except o_data_ready = 1.
- FIFO:
  - Push when i_data_valid && o_data_ready.
  - o_data_ready = !full (combinational from occupancy). A pop in the same cycle does not raise ready while full.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO is cleared only by reset, not by run start or stop.
- State IDLE:
  - o_fir_* = 0.
  - i_run = 1 -> FLUSH.
- State FLUSH (exactly 1 cycle):
  - o_fir_reset = 1; tick counter = 0; phase = 0; o_underrun cleared.
  - i_prescale latched into prescale_q.
  - -> RUN.
- State RUN:
  - Tick counter counts 0..prescale_q and wraps; tick = (count == prescale_q). prescale_q = 0 gives a tick every cycle.
  - Tick with phase != 0:
    - Registered 1-cycle pulse o_fir_enable = 1, o_fir_valid = 0.
    - o_phase = phase, then phase increments mod 4.
  - Tick with phase == 0 and FIFO not empty:
    - o_fir_enable = 1, o_fir_valid = 1, o_fir_data = FIFO head; head is popped.
    - phase -> 1.
  - Tick with phase == 0 and FIFO empty:
    - No enable and no pop; phase stays 0; o_underrun set (sticky).
    - Retry on the next tick. The filter holds its state because enable is 0.
  - Outputs are registered: pulses appear the cycle after the tick condition.
  - o_fir_data holds its last value between valid pulses.
- Stop:
  - i_run = 0 in RUN -> STOP.
  - STOP issues ticks like RUN while phase != 0, without popping.
  - When phase returns to 0 (after the phase-3 enable) -> IDLE.
  - If phase == 0 already when i_run falls -> IDLE directly.
  - i_run = 1 again in STOP: completes to IDLE, then restarts through FLUSH on the next cycle.
- Output validity:
  - o_out_valid = o_fir_enable; o_phase is valid only while o_fir_enable = 1.
  - Filter output rate is 4 samples per symbol.
- Mid-operation reset: immediate return to reset values. The filter is not reset by this block; the next FLUSH clears it.

Decomposition:
- Package fir_poly_pkg:
  - state encoding: IDLE = 0, FLUSH = 1, RUN = 2, STOP = 3;
  - OS_FACTOR = 4;
  - NB_PHASE = 2.
- Sub-module sync_fifo (parameters NB_DATA and FIFO_DEPTH; same clock and reset; push, pop, full, empty, head).
- Sequencer FSM, prescaler and phase counter live in the top module.

Test Plan:
- Reset, then i_run = 1 with prescale 0 and symbols +1, -1 preloaded:
  - o_fir_reset pulses for 1 cycle;
  - enables fire every cycle with o_phase 0,1,2,3,0,1,2,3;
  - o_fir_valid asserts at phases 0 only, with o_fir_data = 0x01, then 0xFF.
- Prescale 2, one symbol:
  - o_fir_enable pulses every 3rd cycle;
  - o_out_valid count = 4 per symbol.
- FIFO full:
  - push 4 symbols while IDLE; ready drops to 0 after the 4th;
  - a 5th valid is not accepted;
  - after the first pop, ready = 1 on the next cycle.
- Underrun:
  - run with 1 symbol, prescale 0;
  - after phases 0..3, the next phase-0 tick has no enable and o_underrun = 1;
  - a pushed symbol resumes enables at phase 0.
- Stop mid-symbol:
  - drop i_run at phase 1;
  - enables continue for phases 2 and 3, no pop, then IDLE with o_busy = 0.
- Assert i_reset low at phase 2:
  - all outputs return to reset values in the same cycle, FIFO empty;
  - a restart shows o_fir_reset, then phase 0.
